timer_arbiter: RTL

- Shares one internal countdown timer among N requesters.
- Each requester raises a request with a load value. The block grants one requester at a time, round-robin, and loads and runs the timer for it.
- It pulses that requester's done bit when the count expires.
- Sits between game/control FSMs and the single timing resource, so several FSMs no longer need private delay counters.

---
 rtl/timer_arb_pkg.sv | 16 +
 rtl/timer_arbiter_rr_pick.sv | 47 ++++
 rtl/timer_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/timer_arb_pkg.sv
// Shared types and constants for the timer arbiter.
// Define TIMER_ARB_FIXED_PRIO_EN to replace round-robin selection with fixed lowest-index priority.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_CNT_W = 10;
    // Load value that gives the standard 1000-cycle game delay.
    localparam int MAX_CNT   = 999;

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational winner select: round-robin after ptr, or lowest index
// when TIMER_ARB_FIXED_PRIO_EN is defined.
module rr_pick
    import timer_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
`ifndef TIMER_ARB_FIXED_PRIO_EN
    input  logic [PW-1:0] ptr,
`endif
    output logic [N-1:0]  win,
    output logic          valid
);

    logic [N-1:0] lo_win;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [N-1:0] hi_win;
`endif

    always_comb begin
        lo_win = '0;
        // Descending scan so the lowest set index is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_win    = '0;
                lo_win[i] = 1'b1;
            end
        end
`ifndef TIMER_ARB_FIXED_PRIO_EN
        hi_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr))) begin
                hi_win    = '0;
                hi_win[i] = 1'b1;
            end
        end
        // Anything above the last owner wins; otherwise wrap to the bottom.
        win = (|hi_win) ? hi_win : lo_win;
`else
        win = lo_win;
`endif
        valid = |req;
    end

endmodule

// File: rtl/timer_arbiter.sv
// One countdown timer shared by N requesters; grants one owner at a time
// and pulses its done bit on expiry. TIMER_ARB_FIXED_PRIO_EN selects fixed priority.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*CNT_W-1:0]   dur,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         done,
    output logic                 busy,
    output logic [CNT_W-1:0]     remain
);

    localparam int PW = $clog2(N);

    state_t             state, state_n;
    logic [N-1:0]       grant_n, done_n, win;
    logic [CNT_W-1:0]   cnt_n, load;
    logic               valid, busy_n;

`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [PW-1:0]      ptr, ptr_n, win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) win_idx = PW'(i);
    end
`endif

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (req),
`ifndef TIMER_ARB_FIXED_PRIO_EN
        .ptr   (ptr),
`endif
        .win   (win),
        .valid (valid)
    );

    always_comb begin
        load = '0;
        for (int i = 0; i < N; i++)
            if (win[i]) load = dur[i*CNT_W +: CNT_W];
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        done_n  = '0;
        cnt_n   = remain;
`ifndef TIMER_ARB_FIXED_PRIO_EN
        ptr_n   = ptr;
`endif
        case (state)
            IDLE: begin
                if (valid) begin
                    state_n = RUN;
                    grant_n = win;
                    cnt_n   = load;
`ifndef TIMER_ARB_FIXED_PRIO_EN
                    ptr_n   = win_idx;
`endif
                end
            end
            RUN: begin
                // Owner dropping its request aborts, even on the expiry cycle.
                if (!(|(req & grant))) begin
                    state_n = IDLE;
                    grant_n = '0;
                    cnt_n   = '0;
                end else if (remain == '0) begin
                    state_n = DONE;
                    done_n  = grant;
                end else begin
                    cnt_n   = remain - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            remain <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr    <= PW'(N - 1);
`endif
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            done   <= done_n;
            busy   <= busy_n;
            remain <= cnt_n;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            ptr    <= ptr_n;
`endif
        end
    end

endmodule
